mem_access_stage: RTL and testbench
===================================

# mem_access_stage

Memory-access (MEM) stage that consumes the EX/MEM pipeline register outputs, performs load/store transactions on a single-outstanding data-memory request/acknowledge bus, stalls the upstream pipeline while a transaction is pending, and registers results into the MEM/WB boundary. It sits between the EX/MEM register and write-back and is the reader side of the EX/MEM interface.

## Interface
- TIMEOUT_CYCLES, 255: WAIT cycles without memAck before abort (used only with MEM_TIMEOUT_EN); range 1..65535
- ABORT_DATA, 32'hDEAD_BEEF: load data returned on timeout abort
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- validIn  in  1  EX/MEM entry holds a live instruction
- aluResIn  in  32  address for memory ops; pass-through result otherwise
- writeDataIn  in  32  store data
- dstRegIn  in  6  destination register
- wbCtrlIn  in  3  write-back control, passed through untouched
- memCtrlIn  in  2  [1]=read, [0]=write
- stall  out  1  combinational; upstream holds EX/MEM contents while high
- memReq  out  1  registered request to data memory
- memWe  out  1  registered; 1=write, 0=read
- memAddr  out  32  registered address
- memWdata  out  32  registered store data
- memAck  in  1  one-cycle acknowledge; memRdata valid in same cycle
- memRdata  in  32  load data
- validOut  out  1  MEM/WB entry valid
- memDataOut  out  32  load data (0 for non-loads)
- aluResOut  out  32  aluResIn copy
- dstRegOut  out  6  dstRegIn copy
- wbCtrlOut  out  3  wbCtrlIn copy
- memErr  out  1  one-cycle pulse: illegal memCtrl (2'b11) or timeout

## Operation
- FSM states: IDLE, WAIT.
- memOp = validIn & (memCtrlIn==2'b10 | memCtrlIn==2'b01).
- IDLE, memOp: latch aluRes/writeData/dstReg/wbCtrl/read-flag internally; memReq<=1, memWe<=memCtrlIn[0], memAddr<=aluResIn, memWdata<=writeDataIn; validOut<=0; ->WAIT.
- IDLE, validIn & memCtrlIn==2'b00: MEM/WB <= inputs, memDataOut<=0, validOut<=1; stay IDLE.
- IDLE, validIn & memCtrlIn==2'b11: no memory access; validOut<=1 with wbCtrlOut<=0 (write-back suppressed); memErr pulse.
- IDLE, !validIn: validOut<=0; other MEM/WB fields hold.
- WAIT, !memAck: memReq and all bus outputs hold; validOut<=0; EX/MEM inputs ignored (latched copies used).
- WAIT, memAck: memReq<=0; MEM/WB <= latched fields; memDataOut<=memRdata for reads, 0 for writes; validOut<=1; ->IDLE.
- stall = (IDLE & memOp) | (WAIT & !memAck). Low in the ack cycle so EX/MEM advances on that edge; no re-issue.

## Timing
- Reset (any state, including WAIT mid-transaction): next edge state=IDLE, memReq=0, memWe=0, memAddr=0, memWdata=0, validOut=0, memDataOut=0, aluResOut=0, dstRegOut=0, wbCtrlOut=0, memErr=0. Pending transaction abandoned; late memAck after reset ignored in IDLE.
- Non-memory instruction: 1-cycle latency to MEM/WB, no stall.
- Memory op: memReq high edge after accept; ack in cycle k after memReq rises -> validOut high edge after ack. Minimum latency 2 cycles (ack in first memReq cycle); stall high for accept cycle plus each non-ack WAIT cycle.
- memAck while memReq low: ignored.
- memErr high exactly one cycle, aligned with the corresponding validOut.

## Configuration
- MEM_TIMEOUT_EN defined: 16-bit counter cleared on WAIT entry, increments each WAIT cycle without ack; on reaching TIMEOUT_CYCLES: memReq<=0, validOut<=1, memDataOut<=ABORT_DATA (reads) or 0 (writes), wbCtrlOut<=latched value, memErr pulse, ->IDLE; stall low in that cycle. Ack in same cycle as expiry wins (normal completion, no memErr).
- MEM_TIMEOUT_EN undefined: no counter; WAIT lasts until memAck; memErr only from illegal memCtrl.

## Test plan
- Reset then validIn=1, memCtrlIn=00, aluResIn=0x1234, dstRegIn=5 -> next edge validOut=1, aluResOut=0x1234, dstRegOut=5, memDataOut=0, stall never high.
- Load memCtrlIn=10, aluResIn=0x100; memAck with memRdata=0xCAFEF00D 3 cycles after memReq rises -> memAddr=0x100, memWe=0, stall high 4 cycles, validOut=1 with memDataOut=0xCAFEF00D, memReq low next edge.
- Store memCtrlIn=01, writeDataIn=0xA5A5A5A5, ack in first memReq cycle -> memWe=1, memWdata=0xA5A5A5A5, single stall cycle, validOut=1, memDataOut=0.
- memCtrlIn=11 with validIn=1 -> no memReq, memErr pulse, validOut=1, wbCtrlOut=0.
- rst asserted in WAIT, memAck pulsed the cycle after -> all outputs 0, state IDLE, no validOut.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, load without ack -> after 4 WAIT cycles memReq=0, memErr=1, validOut=1, memDataOut=0xDEADBEEF.

Source files
------------

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM pipeline stage with a single-outstanding load/store bus and MEM/WB register
// Optional feature: MEM_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES unacknowledged WAIT cycles.
module mem_access_stage
`ifdef MEM_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ABORT_DATA     = 32'hDEAD_BEEF
)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        validIn,
    input  logic [31:0] aluResIn,
    input  logic [31:0] writeDataIn,
    input  logic [5:0]  dstRegIn,
    input  logic [2:0]  wbCtrlIn,
    input  logic [1:0]  memCtrlIn,
    output logic        stall,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWdata,
    input  logic        memAck,
    input  logic [31:0] memRdata,
    output logic        validOut,
    output logic [31:0] memDataOut,
    output logic [31:0] aluResOut,
    output logic [5:0]  dstRegOut,
    output logic [2:0]  wbCtrlOut,
    output logic        memErr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        valid_q, valid_d;
    logic [31:0] mdata_q, mdata_d;
    logic [31:0] alu_q, alu_d;
    logic [5:0]  dst_q, dst_d;
    logic [2:0]  wb_q, wb_d;
    logic        err_q, err_d;
    logic [31:0] lat_alu_q, lat_alu_d;
    logic [5:0]  lat_dst_q, lat_dst_d;
    logic [2:0]  lat_wb_q, lat_wb_d;
    logic        lat_rd_q, lat_rd_d;
`ifdef MEM_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        expire;
    assign expire = (cnt_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    logic mem_op;
    assign mem_op = validIn & ((memCtrlIn == 2'b10) | (memCtrlIn == 2'b01));

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        mdata_d   = mdata_q;
        alu_d     = alu_q;
        dst_d     = dst_q;
        wb_d      = wb_q;
        lat_alu_d = lat_alu_q;
        lat_dst_d = lat_dst_q;
        lat_wb_d  = lat_wb_q;
        lat_rd_d  = lat_rd_q;
        stall     = 1'b0;
`ifdef MEM_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    lat_alu_d = aluResIn;
                    lat_dst_d = dstRegIn;
                    lat_wb_d  = wbCtrlIn;
                    lat_rd_d  = memCtrlIn[1];
                    req_d     = 1'b1;
                    we_d      = memCtrlIn[0];
                    addr_d    = aluResIn;
                    wdata_d   = writeDataIn;
`ifdef MEM_TIMEOUT_EN
                    cnt_d     = 16'd0;
`endif
                    state_d   = S_WAIT;
                end else if (validIn) begin
                    // Illegal read+write still retires, but with write-back suppressed.
                    valid_d = 1'b1;
                    alu_d   = aluResIn;
                    dst_d   = dstRegIn;
                    mdata_d = 32'd0;
                    wb_d    = (memCtrlIn == 2'b11) ? 3'd0 : wbCtrlIn;
                    err_d   = (memCtrlIn == 2'b11);
                end
            end
            S_WAIT: begin
                if (memAck) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    alu_d   = lat_alu_q;
                    dst_d   = lat_dst_q;
                    wb_d    = lat_wb_q;
                    mdata_d = lat_rd_q ? memRdata : 32'd0;
                    state_d = S_IDLE;
                end
`ifdef MEM_TIMEOUT_EN
                else if (expire) begin
                    req_d   = 1'b0;
                    valid_d = 1'b1;
                    alu_d   = lat_alu_q;
                    dst_d   = lat_dst_q;
                    wb_d    = lat_wb_q;
                    mdata_d = lat_rd_q ? ABORT_DATA : 32'd0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                end
`else
                else begin
                    stall = 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            valid_q   <= 1'b0;
            mdata_q   <= 32'd0;
            alu_q     <= 32'd0;
            dst_q     <= 6'd0;
            wb_q      <= 3'd0;
            err_q     <= 1'b0;
            lat_alu_q <= 32'd0;
            lat_dst_q <= 6'd0;
            lat_wb_q  <= 3'd0;
            lat_rd_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= 16'd0;
`endif
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            valid_q   <= valid_d;
            mdata_q   <= mdata_d;
            alu_q     <= alu_d;
            dst_q     <= dst_d;
            wb_q      <= wb_d;
            err_q     <= err_d;
            lat_alu_q <= lat_alu_d;
            lat_dst_q <= lat_dst_d;
            lat_wb_q  <= lat_wb_d;
            lat_rd_q  <= lat_rd_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign memReq     = req_q;
    assign memWe      = we_q;
    assign memAddr    = addr_q;
    assign memWdata   = wdata_q;
    assign validOut   = valid_q;
    assign memDataOut = mdata_q;
    assign aluResOut  = alu_q;
    assign dstRegOut  = dst_q;
    assign wbCtrlOut  = wb_q;
    assign memErr     = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - randomized transaction-level checks of mem_access_stage
module tb_mem_access_stage;

`ifdef MEM_TIMEOUT_EN
    localparam int TO   = 4;
    localparam int MAXD = TO - 1;
`else
    localparam int MAXD = 5;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        validIn;
    logic [31:0] aluResIn, writeDataIn;
    logic [5:0]  dstRegIn;
    logic [2:0]  wbCtrlIn;
    logic [1:0]  memCtrlIn;
    logic        stall, memReq, memWe;
    logic [31:0] memAddr, memWdata;
    logic        memAck;
    logic [31:0] memRdata;
    logic        validOut;
    logic [31:0] memDataOut, aluResOut;
    logic [5:0]  dstRegOut;
    logic [2:0]  wbCtrlOut;
    logic        memErr;

    always #5 clk = ~clk;

`ifdef MEM_TIMEOUT_EN
    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
`else
    mem_access_stage dut (
`endif
        .clk(clk), .rst(rst), .validIn(validIn), .aluResIn(aluResIn),
        .writeDataIn(writeDataIn), .dstRegIn(dstRegIn), .wbCtrlIn(wbCtrlIn),
        .memCtrlIn(memCtrlIn), .stall(stall), .memReq(memReq), .memWe(memWe),
        .memAddr(memAddr), .memWdata(memWdata), .memAck(memAck), .memRdata(memRdata),
        .validOut(validOut), .memDataOut(memDataOut), .aluResOut(aluResOut),
        .dstRegOut(dstRegOut), .wbCtrlOut(wbCtrlOut), .memErr(memErr)
    );

    int total = 0;
    int bad   = 0;

    // Expected MEM/WB contents; known=0 when the last retirement left fields undefined.
    logic [31:0] e_alu, e_md;
    logic [5:0]  e_dst;
    logic [2:0]  e_wb;
    bit          known;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic ev, input logic eerr);
        check({tag, ".valid"}, 32'(validOut), 32'(ev));
        check({tag, ".err"},   32'(memErr),   32'(eerr));
        check({tag, ".req"},   32'(memReq),   32'd0);
        if (known) begin
            check({tag, ".alu"},  aluResOut,         e_alu);
            check({tag, ".dst"},  32'(dstRegOut),    32'(e_dst));
            check({tag, ".wb"},   32'(wbCtrlOut),    32'(e_wb));
            check({tag, ".mdat"}, memDataOut,        e_md);
        end
    endtask

    task automatic op_bubble();
        validIn   = 1'b0;
        memCtrlIn = 2'($urandom);
        aluResIn  = $urandom;
        memAck    = 1'($urandom);
        memRdata  = $urandom;
        #1 check("bub.stall", 32'(stall), 32'd0);
        @(negedge clk);
        check_out("bub", 1'b0, 1'b0);
    endtask

    task automatic op_alu(input bit ill, input logic [31:0] alu, input logic [5:0] dst,
                          input logic [2:0] wb);
        validIn     = 1'b1;
        memCtrlIn   = ill ? 2'b11 : 2'b00;
        aluResIn    = alu;
        dstRegIn    = dst;
        wbCtrlIn    = wb;
        writeDataIn = $urandom;
        memAck      = 1'($urandom);
        memRdata    = $urandom;
        #1 check("alu.stall", 32'(stall), 32'd0);
        @(negedge clk);
        if (ill) begin
            known = 1'b0;
            check("ill.wb", 32'(wbCtrlOut), 32'd0);
            check_out("ill", 1'b1, 1'b1);
        end else begin
            e_alu = alu; e_dst = dst; e_wb = wb; e_md = 32'd0; known = 1'b1;
            check_out("alu", 1'b1, 1'b0);
        end
    endtask

    task automatic op_mem(input bit rd, input logic [31:0] alu, input logic [31:0] wd,
                          input logic [5:0] dst, input logic [2:0] wb, input int delay,
                          input logic [31:0] rdata);
        int stalls = 0;
        validIn     = 1'b1;
        memCtrlIn   = rd ? 2'b10 : 2'b01;
        aluResIn    = alu;
        writeDataIn = wd;
        dstRegIn    = dst;
        wbCtrlIn    = wb;
        memAck      = 1'b0;
        #1 if (stall) stalls++;
        @(negedge clk);
        check("mem.req",   32'(memReq),   32'd1);
        check("mem.we",    32'(memWe),    32'(!rd));
        check("mem.addr",  memAddr,       alu);
        check("mem.wdata", memWdata,      wd);
        check("mem.vout",  32'(validOut), 32'd0);
        for (int w = 0; w <= delay; w++) begin
            aluResIn    = $urandom;
            writeDataIn = $urandom;
            dstRegIn    = 6'($urandom);
            wbCtrlIn    = 3'($urandom);
            memCtrlIn   = 2'($urandom);
            memAck      = (w == delay);
            memRdata    = (w == delay) ? rdata : $urandom;
            #1 if (stall) stalls++;
            @(negedge clk);
            if (w < delay) begin
                check("wait.req",  32'(memReq),   32'd1);
                check("wait.addr", memAddr,       alu);
                check("wait.vout", 32'(validOut), 32'd0);
            end
        end
        memAck = 1'b0;
        check("mem.stalls", 32'(stalls), 32'(delay + 1));
        e_alu = alu; e_dst = dst; e_wb = wb; e_md = rd ? rdata : 32'd0; known = 1'b1;
        check_out(rd ? "load" : "store", 1'b1, 1'b0);
    endtask

    initial begin
        rst = 1'b1; validIn = 1'b0; aluResIn = '0; writeDataIn = '0; dstRegIn = '0;
        wbCtrlIn = '0; memCtrlIn = '0; memAck = 1'b0; memRdata = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        e_alu = '0; e_dst = '0; e_wb = '0; e_md = '0; known = 1'b1;
        check("rst.we", 32'(memWe), 32'd0);
        check("rst.addr", memAddr, 32'd0);
        check_out("rst", 1'b0, 1'b0);

        op_alu(1'b0, 32'h1234, 6'd5, 3'd3);
        op_mem(1'b1, 32'h100, 32'h0, 6'd7, 3'd1, 3, 32'hCAFEF00D);
        op_mem(1'b0, 32'h200, 32'hA5A5A5A5, 6'd8, 3'd2, 0, 32'h0);
        op_alu(1'b1, 32'h55, 6'd9, 3'd7);
        op_bubble();

        // Reset in the middle of a transaction, then a stray acknowledge.
        validIn = 1'b1; memCtrlIn = 2'b10; aluResIn = 32'h300; dstRegIn = 6'd4; wbCtrlIn = 3'd5;
        @(negedge clk);
        check("rstw.req", 32'(memReq), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; validIn = 1'b0; memAck = 1'b1; memRdata = 32'h12345678;
        @(negedge clk);
        memAck = 1'b0;
        e_alu = '0; e_dst = '0; e_wb = '0; e_md = '0; known = 1'b1;
        check("rstw.we", 32'(memWe), 32'd0);
        check("rstw.addr", memAddr, 32'd0);
        check("rstw.wdata", memWdata, 32'd0);
        check("rstw.stall", 32'(stall), 32'd0);
        check_out("rstw", 1'b0, 1'b0);

`ifdef MEM_TIMEOUT_EN
        validIn = 1'b1; memCtrlIn = 2'b10; aluResIn = 32'h400; dstRegIn = 6'd11; wbCtrlIn = 3'd6;
        memAck = 1'b0;
        @(negedge clk);
        for (int w = 0; w < TO; w++) begin
            #1 check("to.stall", 32'(stall), 32'(w < TO - 1));
            @(negedge clk);
        end
        e_alu = 32'h400; e_dst = 6'd11; e_wb = 3'd6; e_md = 32'hDEADBEEF; known = 1'b1;
        check_out("to", 1'b1, 1'b1);
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    op_bubble();
                2, 3:    op_alu(1'b0, $urandom, 6'($urandom), 3'($urandom));
                4:       op_alu(1'b1, $urandom, 6'($urandom), 3'($urandom));
                5, 6, 7: op_mem(1'b1, $urandom, $urandom, 6'($urandom), 3'($urandom),
                                $urandom_range(0, MAXD), $urandom);
                default: op_mem(1'b0, $urandom, $urandom, 6'($urandom), 3'($urandom),
                                $urandom_range(0, MAXD), $urandom);
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
